mem_wb_stage: RTL and testbench
===============================

# mem_wb_stage

Parametrised MEM→WB pipeline boundary for the next core generation. It carries LANES independent register-writeback requests per beat under a valid/ready handshake. It supports synchronous flush and suppresses writes to x0. An optional 2-entry skid buffer gives a fully registered in_ready, so back-pressure from writeback arbitration never forms a combinational path into MEM. A saturating stall counter is exported for performance monitoring.

## Interface
Parameters:
- DATA_W, 32, width of one writeback data word.
- ADDR_W, 5, register address width.
- LANES, 1, number of writeback lanes per beat (1..4).
- SKID, 1, 1 = 2-entry skid buffer with registered in_ready; 0 = single entry with pass-through ready.
- CNT_W, 16, width of the stall counter.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- flush  in  1  synchronous discard of all held beats (branch/exception squash).
- in_valid  in  1  MEM offers a beat.
- in_ready  out  1  stage accepts a beat this cycle.
- in_rd_data  in  LANES*DATA_W  per-lane write data; lane i is at [i*DATA_W +: DATA_W].
- in_rd_addr  in  LANES*ADDR_W  per-lane destination register.
- in_rd_enable  in  LANES  per-lane write request.
- out_valid  out  1  beat available to WB.
- out_ready  in  1  WB consumes the beat.
- out_rd_data  out  LANES*DATA_W  head-beat data.
- out_rd_addr  out  LANES*ADDR_W  head-beat addresses.
- out_rd_enable  out  LANES  qualified write enables.
- stall_cnt  out  CNT_W  saturating count of cycles with out_valid=1 and out_ready=0.

## Operation
- Handshakes: accept when in_valid && in_ready. Retire when out_valid && out_ready.
- States:
  - EMPTY: nothing held.
  - FULL: head register holds a beat.
  - SKIDDED: head and skid both hold beats. Reachable only when SKID=1.
- Transitions:
  - EMPTY→FULL on accept.
  - FULL→EMPTY on retire without accept.
  - FULL stays FULL on accept+retire; the head takes the new beat.
  - FULL→SKIDDED on accept without retire; the new beat goes to skid.
  - SKIDDED→FULL on retire; skid moves to head.
- in_ready:
  - SKID=1: in_ready = !skid_valid, a register output. In SKIDDED, in_ready=0.
  - SKID=0: in_ready = !out_valid || out_ready (combinational).
- out_valid=1 in FULL and SKIDDED.
- out_rd_enable[i] = head_enable[i] && out_valid.
- x0 suppression: on capture, enable[i] is stored as in_rd_enable[i] && (in_rd_addr[i] != 0). Data and addr are stored unmodified.
- Data/addr outputs hold their last value when out_valid=0.
- Beat order is strictly FIFO; lanes within a beat never reorder.
- Flush:
  - Next state is EMPTY. Any same-cycle accept is dropped.
  - stall_cnt is NOT cleared.
  - Data/addr registers are not cleared.
- Reset: next state EMPTY, all data/addr/enable registers 0, stall_cnt 0. rst has priority over flush.
- stall_cnt increments by 1 on each cycle where out_valid && !out_ready, and saturates at 2^CNT_W−1 (no wrap).

## Timing
- Latency: a beat accepted at edge N is visible on out_* after edge N, with out_valid=1 in cycle N+1.
- Throughput: 1 beat/cycle while out_ready=1, for both SKID settings.
- With SKID=1, in_ready falls one cycle after the stall that fills skid. The skid entry absorbs the beat MEM already launched.
- While rst is high: out_valid=0, out_rd_enable=0, in_ready=0. in_ready rises the cycle after rst deasserts.
- out_ready is ignored when out_valid=0.
- No combinational path from out_ready to in_ready when SKID=1.

## Structure
- The shared package ypu_pkg holds:
  - RegLen and RegAddrLen (the defaults for DATA_W and ADDR_W).
  - ResetEnable, WriteDisable, ZERO_WORD.
  - The state encoding typedef: EMPTY=2'b00, FULL=2'b01, SKIDDED=2'b11.
- One sub-module, wb_skid_buf: a generic payload-width skid register pair with occupancy flags. It is instantiated once with payload width LANES*(DATA_W+ADDR_W+1).
- The x0 qualification, flush handling and stall counter live in mem_wb_stage.

## Test plan
- Reset: hold rst 3 cycles with in_valid=1 → out_valid=0, out_rd_enable=0, stall_cnt=0, in_ready=0. First accept occurs on the cycle after deassert.
- Streaming, LANES=2, out_ready=1: send 8 beats (data 0x1000+k, addr 1+k) → 8 beats out in order, each 1 cycle after accept, no bubbles.
- Back-pressure, SKID=1:
  - Drop out_ready for 4 cycles mid-stream → exactly 2 beats held, then in_ready=0, and stall_cnt=4.
  - Release out_ready → held beats emerge in order, with no loss or duplication.
- x0 suppression: lane0 addr=0 with enable=1 and data 0xDEADBEEF → out_rd_enable[0]=0, while lane1 (addr 7, enable 1) has out_rd_enable[1]=1.
- Flush in SKIDDED state, with in_valid=1 in the same cycle → next cycle out_valid=0 and in_ready=1; the same-cycle beat never appears; stall_cnt is unchanged.
- Saturation, CNT_W=4: 20 stall cycles → stall_cnt=15 and stays 15. SKID=0 variant: full throughput with out_ready toggling 1/0 each cycle, and no beat is lost.

Source files
------------

// File: rtl/ypu_pkg.sv
// ypu_pkg: shared register-file widths, reset/write constants and MEM/WB occupancy encoding
package ypu_pkg;
  localparam int RegLen = 32;
  localparam int RegAddrLen = 5;
  localparam logic ResetEnable = 1'b1;
  localparam logic WriteDisable = 1'b0;
  localparam logic [RegLen-1:0] ZERO_WORD = '0;
  typedef enum logic [1:0] {EMPTY = 2'b00, FULL = 2'b01, SKIDDED = 2'b11} wb_state_e;
endpackage

// File: rtl/mem_wb_stage_if.sv
// mem_wb_stage_if: MEM-side and WB-side valid/ready writeback buses of the MEM/WB boundary
interface mem_wb_stage_if import ypu_pkg::*; #(
  parameter int LANES = 1,
  parameter int DATA_W = RegLen,
  parameter int ADDR_W = RegAddrLen
);
  logic in_valid, in_ready, out_valid, out_ready;
  logic [LANES*DATA_W-1:0] in_rd_data, out_rd_data;
  logic [LANES*ADDR_W-1:0] in_rd_addr, out_rd_addr;
  logic [LANES-1:0] in_rd_enable, out_rd_enable;
  modport master (
    output in_valid, in_rd_data, in_rd_addr, in_rd_enable, out_ready,
    input in_ready, out_valid, out_rd_data, out_rd_addr, out_rd_enable
  );
  modport slave (
    input in_valid, in_rd_data, in_rd_addr, in_rd_enable, out_ready,
    output in_ready, out_valid, out_rd_data, out_rd_addr, out_rd_enable
  );
endinterface

// File: rtl/mem_wb_stage_skid.sv
// wb_skid_buf: head/skid register pair with occupancy FSM and a registered "skid free" ready
module wb_skid_buf import ypu_pkg::*; #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush_i,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic [W-1:0] din_i,
  output logic [W-1:0] head_o,
  output logic         head_valid_o,
  output logic         ready_o
);
  wb_state_e state_q;
  logic [W-1:0] head_q, skid_q;
  logic ready_q;
  always_ff @(posedge clk) begin
    if (rst == ResetEnable) begin
      state_q <= EMPTY;
      head_q <= '0;
      skid_q <= '0;
      ready_q <= 1'b0;
    end else if (flush_i) begin
      state_q <= EMPTY;
      ready_q <= 1'b1;
    end else begin
      ready_q <= 1'b1;
      case (state_q)
        EMPTY: if (push_i) begin
          head_q <= din_i;
          state_q <= FULL;
        end
        FULL: if (push_i && pop_i) head_q <= din_i;
        else if (push_i) begin
          skid_q <= din_i;
          state_q <= SKIDDED;
          ready_q <= 1'b0;
        end else if (pop_i) state_q <= EMPTY;
        SKIDDED: if (pop_i) begin
          head_q <= skid_q;
          state_q <= FULL;
        end else ready_q <= 1'b0;
        default: state_q <= EMPTY;
      endcase
    end
  end
  assign head_o = head_q;
  assign head_valid_o = state_q != EMPTY;
  assign ready_o = ready_q;
endmodule

// File: rtl/mem_wb_stage.sv
// mem_wb_stage: MEM->WB boundary with x0 write suppression, flush and saturating stall counter
module mem_wb_stage import ypu_pkg::*; #(
  parameter int DATA_W = RegLen,
  parameter int ADDR_W = RegAddrLen,
  parameter int LANES = 1,
  parameter int SKID = 1,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  mem_wb_stage_if.slave    bus,
  output logic [CNT_W-1:0] stall_cnt
);
  localparam int PW = LANES * (DATA_W + ADDR_W + 1);
  logic [LANES-1:0] en_in, head_en;
  logic [PW-1:0] head;
  logic head_valid, rdy, push, pop;
  logic [CNT_W-1:0] stall_q, stall_d;
  always_comb begin
    en_in = '0;
    for (int i = 0; i < LANES; i++)
      en_in[i] = (bus.in_rd_addr[i*ADDR_W +: ADDR_W] == ADDR_W'(ZERO_WORD)) ? WriteDisable : bus.in_rd_enable[i];
  end
  assign pop = head_valid && bus.out_ready;
  assign push = bus.in_valid && bus.in_ready && !flush;
  // rdy doubles as the out-of-reset qualifier when the skid entry is absent
  assign bus.in_ready = (SKID != 0) ? rdy : rdy && (!head_valid || bus.out_ready);
  wb_skid_buf #(.W(PW)) u_skid (
    .clk(clk),
    .rst(rst),
    .flush_i(flush),
    .push_i(push),
    .pop_i(pop),
    .din_i({en_in, bus.in_rd_addr, bus.in_rd_data}),
    .head_o(head),
    .head_valid_o(head_valid),
    .ready_o(rdy)
  );
  assign {head_en, bus.out_rd_addr, bus.out_rd_data} = head;
  assign bus.out_valid = head_valid;
  assign bus.out_rd_enable = head_en & {LANES{head_valid}};
  always_comb stall_d = (head_valid && !bus.out_ready && stall_q != '1) ? stall_q + CNT_W'(1) : stall_q;
  always_ff @(posedge clk) begin
    if (rst == ResetEnable) stall_q <= '0;
    else stall_q <= stall_d;
  end
  assign stall_cnt = stall_q;
endmodule

// File: tb/tb_mem_wb_stage.sv
// tb_mem_wb_stage: directed vector table for a 2-lane skid instance plus a 1-lane pass-through instance
module tb_mem_wb_stage;
  logic clk = 1'b0;
  logic rst, fla, flb;
  logic [3:0] sca;
  logic [15:0] scb;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;

  mem_wb_stage_if #(.LANES(2)) ia ();
  mem_wb_stage_if #(.LANES(1)) ib ();
  mem_wb_stage #(.LANES(2), .SKID(1), .CNT_W(4)) ua (.clk(clk), .rst(rst), .flush(fla), .bus(ia), .stall_cnt(sca));
  mem_wb_stage #(.LANES(1), .SKID(0), .CNT_W(16)) ub (.clk(clk), .rst(rst), .flush(flb), .bus(ib), .stall_cnt(scb));

  typedef struct packed {
    logic iv, fl, ordy;
    int k;
    logic [1:0] ien;
    logic eov;
    int ek;
    logic [1:0] een;
    logic eir;
    logic [3:0] esc;
  } vec_t;
  vec_t tv [24];

  function automatic logic [63:0] beat_d(int k);
    return (k == 20) ? {32'h77, 32'hDEADBEEF} : {32'h2000 + 32'(k), 32'h1000 + 32'(k)};
  endfunction
  function automatic logic [9:0] beat_a(int k);
    return (k == 20) ? {5'd7, 5'd0} : {5'(9 + k), 5'(1 + k)};
  endfunction
  function automatic vec_t mk(logic iv, logic fl, logic ordy, int k, logic [1:0] ien,
                              logic eov, int ek, logic [1:0] een, logic eir, logic [3:0] esc);
    return '{iv, fl, ordy, k, ien, eov, ek, een, eir, esc};
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    logic [36:0] q [$];
    logic [36:0] e;
    int sent, got, bst, drain;
    tv[0] = mk(1, 0, 1, 0, 3, 0, -1, 0, 1, 0);
    for (int k = 1; k < 8; k++) tv[k] = mk(1, 0, 1, k, 3, 1, k - 1, 3, 1, 0);
    tv[8]  = mk(1, 0, 0, 8, 3, 1, 7, 3, 1, 0);
    tv[9]  = mk(1, 0, 0, 9, 3, 1, 7, 3, 0, 1);
    tv[10] = mk(1, 0, 0, 9, 3, 1, 7, 3, 0, 2);
    tv[11] = mk(1, 0, 0, 9, 3, 1, 7, 3, 0, 3);
    tv[12] = mk(1, 0, 1, 9, 3, 1, 7, 3, 0, 4);
    tv[13] = mk(1, 0, 1, 9, 3, 1, 8, 3, 1, 4);
    tv[14] = mk(0, 0, 1, 0, 0, 1, 9, 3, 1, 4);
    tv[15] = mk(1, 0, 1, 20, 3, 0, 9, 0, 1, 4);
    tv[16] = mk(1, 0, 0, 10, 1, 1, 20, 2, 1, 4);
    tv[17] = mk(0, 0, 1, 0, 0, 1, 20, 2, 0, 5);
    tv[18] = mk(1, 0, 0, 11, 3, 1, 10, 1, 1, 5);
    tv[19] = mk(1, 1, 1, 12, 3, 1, 10, 1, 0, 6);
    tv[20] = mk(1, 1, 1, 13, 3, 0, 10, 0, 1, 6);
    tv[21] = mk(0, 0, 1, 0, 0, 0, 10, 0, 1, 6);
    tv[22] = mk(1, 0, 1, 14, 3, 0, 10, 0, 1, 6);
    tv[23] = mk(0, 0, 1, 0, 0, 1, 14, 3, 1, 6);

    rst = 1; fla = 0; flb = 0;
    ia.in_valid = 1; ia.in_rd_data = beat_d(0); ia.in_rd_addr = beat_a(0); ia.in_rd_enable = 3; ia.out_ready = 0;
    ib.in_valid = 1; ib.in_rd_data = 32'h1; ib.in_rd_addr = 5'd1; ib.in_rd_enable = 1; ib.out_ready = 0;
    repeat (3) @(negedge clk);
    chk("a_rst_out_valid", ia.out_valid, 0);
    chk("a_rst_out_en", ia.out_rd_enable, 0);
    chk("a_rst_in_ready", ia.in_ready, 0);
    chk("a_rst_stall", sca, 0);
    chk("b_rst_out_valid", ib.out_valid, 0);
    chk("b_rst_out_en", ib.out_rd_enable, 0);
    chk("b_rst_in_ready", ib.in_ready, 0);
    chk("b_rst_stall", scb, 0);
    rst = 0;
    ib.in_valid = 0;

    for (int r = 0; r < 24; r++) begin
      @(negedge clk);
      ia.in_valid = tv[r].iv; fla = tv[r].fl; ia.out_ready = tv[r].ordy;
      ia.in_rd_data = beat_d(tv[r].k); ia.in_rd_addr = beat_a(tv[r].k); ia.in_rd_enable = tv[r].ien;
      #1;
      chk($sformatf("v%0d_out_valid", r), ia.out_valid, tv[r].eov);
      chk($sformatf("v%0d_out_en", r), ia.out_rd_enable, tv[r].een);
      chk($sformatf("v%0d_in_ready", r), ia.in_ready, tv[r].eir);
      chk($sformatf("v%0d_stall", r), sca, tv[r].esc);
      if (tv[r].ek >= 0) begin
        chk($sformatf("v%0d_data", r), ia.out_rd_data, beat_d(tv[r].ek));
        chk($sformatf("v%0d_addr", r), ia.out_rd_addr, beat_a(tv[r].ek));
      end
    end

    // saturation: counter sits at 6, needs 9 stall cycles to reach 15
    @(negedge clk);
    fla = 0; ia.in_valid = 1; ia.in_rd_data = beat_d(15); ia.in_rd_addr = beat_a(15); ia.in_rd_enable = 3; ia.out_ready = 0;
    @(negedge clk);
    ia.in_valid = 0;
    for (int n = 1; n <= 20; n++) begin
      @(posedge clk); #1;
      if (n == 8) chk("sat_14", sca, 14);
      if (n == 9) chk("sat_15", sca, 15);
      if (n == 20) chk("sat_hold", sca, 15);
    end
    @(negedge clk);
    ia.out_ready = 1;
    #1;
    chk("sat_out_valid", ia.out_valid, 1);
    chk("sat_data", ia.out_rd_data, beat_d(15));
    @(negedge clk);
    chk("sat_drained", ia.out_valid, 0);

    sent = 0; got = 0; bst = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      ib.in_valid = 1; ib.in_rd_data = 32'h500 + 32'(sent); ib.in_rd_addr = 5'(sent); ib.in_rd_enable = 1;
      ib.out_ready = (c % 2) == 0;
      #1;
      chk("b_ready_path", ib.in_ready, !ib.out_valid || ib.out_ready);
      if (ib.out_valid && !ib.out_ready) bst++;
      if (ib.out_valid && ib.out_ready) begin
        if (q.size() == 0) chk("b_spurious_beat", 1, 0);
        else begin
          e = q.pop_front();
          chk("b_data", ib.out_rd_data, e[31:0]);
          chk("b_addr", ib.out_rd_addr, e[36:32]);
          chk("b_en", ib.out_rd_enable, e[36:32] != 0);
          got++;
        end
      end
      if (ib.in_valid && ib.in_ready) begin
        q.push_back({5'(sent), 32'h500 + 32'(sent)});
        sent++;
      end
    end
    @(negedge clk);
    ib.in_valid = 0; ib.out_ready = 1;
    drain = 0;
    while (q.size() != 0 && drain < 10) begin
      #1;
      if (ib.out_valid) begin
        e = q.pop_front();
        chk("b_drain_data", ib.out_rd_data, e[31:0]);
        got++;
      end
      drain++;
      @(negedge clk);
    end
    chk("b_drain_bound", q.size(), 0);
    chk("b_sent", sent, 20);
    chk("b_got", got, 20);
    chk("b_stall", scb, bst);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
